// File: rtl/enigma_pkg.sv
// Shared Enigma constants: alphabet size, historical rotor wirings and
// notches, and the modular helpers used by the rotor datapath.
package enigma_pkg;

  localparam int N_LETTERS = 26;
  localparam int IDX_W     = $clog2(N_LETTERS);

  // Entry k (bits [k*IDX_W +: IDX_W]) is the output contact for input contact k.
  typedef logic [N_LETTERS*IDX_W-1:0] wiring_t;

  // Listed from contact Z down to contact A so that A lands in the low bits.
  // EKMFLGDQVZNTOWYHXUSPAIBRCJ
  localparam wiring_t ROTOR_I = {
    5'd9,  5'd2,  5'd17, 5'd1,  5'd8,  5'd0,  5'd15, 5'd18, 5'd20, 5'd23,
    5'd7,  5'd24, 5'd22, 5'd14, 5'd19, 5'd13, 5'd25, 5'd21, 5'd16, 5'd3,
    5'd6,  5'd11, 5'd5,  5'd12, 5'd10, 5'd4};
  // AJDKSIRUXBLHWTMCQGZNPYFVOE
  localparam wiring_t ROTOR_II = {
    5'd4,  5'd14, 5'd21, 5'd5,  5'd24, 5'd15, 5'd13, 5'd25, 5'd6,  5'd16,
    5'd2,  5'd12, 5'd19, 5'd22, 5'd7,  5'd11, 5'd1,  5'd23, 5'd20, 5'd17,
    5'd8,  5'd18, 5'd10, 5'd3,  5'd9,  5'd0};
  // BDFHJLCPRTXVZNYEIWGAKMOUSQ
  localparam wiring_t ROTOR_III = {
    5'd16, 5'd18, 5'd20, 5'd14, 5'd12, 5'd10, 5'd0,  5'd6,  5'd22, 5'd8,
    5'd4,  5'd24, 5'd13, 5'd25, 5'd21, 5'd23, 5'd19, 5'd17, 5'd15, 5'd2,
    5'd11, 5'd9,  5'd7,  5'd5,  5'd3,  5'd1};
  // ESOVPZJAYQUIRHXLNFTGKDCMWB
  localparam wiring_t ROTOR_IV = {
    5'd1,  5'd22, 5'd12, 5'd2,  5'd3,  5'd10, 5'd6,  5'd19, 5'd5,  5'd13,
    5'd11, 5'd23, 5'd7,  5'd17, 5'd8,  5'd20, 5'd16, 5'd24, 5'd0,  5'd9,
    5'd25, 5'd15, 5'd21, 5'd14, 5'd18, 5'd4};
  // VZBRGITYUPSDNHLXAWMJQOFECK
  localparam wiring_t ROTOR_V = {
    5'd10, 5'd2,  5'd4,  5'd5,  5'd14, 5'd16, 5'd9,  5'd22, 5'd0,  5'd12,
    5'd23, 5'd11, 5'd7,  5'd13, 5'd3,  5'd18, 5'd15, 5'd20, 5'd8,  5'd17,
    5'd6,  5'd19, 5'd24, 5'd1,  5'd25, 5'd21};

  localparam int NOTCH_I   = 16;  // Q
  localparam int NOTCH_II  = 4;   // E
  localparam int NOTCH_III = 21;  // V
  localparam int NOTCH_IV  = 9;   // J
  localparam int NOTCH_V   = 25;  // Z

  // Builds the reverse-direction table: if contact k maps to m, m maps to k.
  function automatic wiring_t invert_wiring(input wiring_t w);
    wiring_t inv;
    inv = '0;
    for (int k = 0; k < N_LETTERS; k++) begin
      inv[int'(w[k*IDX_W +: IDX_W])*IDX_W +: IDX_W] = IDX_W'(k);
    end
    return inv;
  endfunction

  // (a + b) mod n for a, b < n; a single subtract suffices since a + b < 2n.
  function automatic logic [IDX_W-1:0] mod_add(input logic [IDX_W:0] a,
                                               input logic [IDX_W:0] b,
                                               input logic [IDX_W:0] n);
    logic [IDX_W:0] s;
    s = a + b;
    if (s >= n) s = s - n;
    return s[IDX_W-1:0];
  endfunction

  // (a - b) mod n for a, b < n, computed as a + n - b to stay non-negative.
  function automatic logic [IDX_W-1:0] mod_sub(input logic [IDX_W:0] a,
                                               input logic [IDX_W:0] b,
                                               input logic [IDX_W:0] n);
    logic [IDX_W:0] s;
    s = a + n - b;
    if (s >= n) s = s - n;
    return s[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/rotor_perm.sv
// Combinational rotor permutation: one-hot letter in, rotated through the
// wiring table by the current offset, one-hot letter out, plus a one-hot check.
module rotor_perm import enigma_pkg::*; #(
  parameter int             N     = N_LETTERS,
  parameter int             W     = $clog2(N),
  parameter logic [N*W-1:0] TABLE = ROTOR_I
) (
  input  logic [N-1:0] letter,
  input  logic [W-1:0] off,
  output logic [N-1:0] result,
  output logic         err
);

  localparam logic [W:0] NV = (W+1)'(N);

  logic         one_hot;
  logic [W-1:0] idx;
  logic [W-1:0] contact;
  logic [W-1:0] mapped;
  logic [W-1:0] out_idx;

  // Decode, shift into rotor frame, look up wiring, shift back, re-encode.
  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    idx     = '0;
    result  = '0;
    one_hot = (letter != '0) && ((letter & (letter - N'(1))) == '0);
    for (int k = 0; k < N; k++) begin
      if (letter[k]) idx = idx | W'(k);
    end
    contact = mod_add({1'b0, idx}, {1'b0, off}, NV);
    mapped  = TABLE[int'(contact)*W +: W];
    out_idx = mod_sub({1'b0, mapped}, {1'b0, off}, NV);
    if (one_hot) result = N'(1) << out_idx;
    err = ~one_hot;
  end

endmodule

// File: rtl/stepping_rotor.sv
// One clocked Enigma rotor stage: position/ring registers, turnover carry,
// and registered forward and inverse translation paths.
module stepping_rotor import enigma_pkg::*; #(
  parameter int             N      = N_LETTERS,
  parameter int             W      = $clog2(N),
  parameter logic [N*W-1:0] WIRING = ROTOR_I,
  parameter int             NOTCH  = NOTCH_I
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load_i,
  input  logic [W-1:0] pos_i,
  input  logic [W-1:0] ring_i,
  input  logic         step_i,
  input  logic         fwd_valid_i,
  input  logic [N-1:0] fwd_i,
  input  logic         inv_valid_i,
  input  logic [N-1:0] inv_i,
  output logic         fwd_valid_o,
  output logic [N-1:0] fwd_o,
  output logic         fwd_err_o,
  output logic         inv_valid_o,
  output logic [N-1:0] inv_o,
  output logic         inv_err_o,
  output logic [W-1:0] pos_o,
  output logic         at_notch_o,
  output logic         carry_o
);

  localparam logic [N*W-1:0] INV_WIRING = invert_wiring(WIRING);
  localparam logic [W:0]     NV         = (W+1)'(N);
  localparam logic [W-1:0]   NOTCH_IDX  = W'(NOTCH);

  logic [W-1:0] pos_q;
  logic [W-1:0] ring_q;
  logic [W-1:0] off;
  logic         carry_q;
  logic [N-1:0] fwd_res;
  logic [N-1:0] inv_res;
  logic         fwd_bad;
  logic         inv_bad;

  // Offset between the rotor's physical position and its ring setting.
  assign off = mod_sub({1'b0, pos_q}, {1'b0, ring_q}, NV);

  rotor_perm #(.N(N), .W(W), .TABLE(WIRING)) u_fwd (
    .letter (fwd_i),
    .off    (off),
    .result (fwd_res),
    .err    (fwd_bad)
  );

  rotor_perm #(.N(N), .W(W), .TABLE(INV_WIRING)) u_inv (
    .letter (inv_i),
    .off    (off),
    .result (inv_res),
    .err    (inv_bad)
  );

  // Position and ring update: load beats step; carry pulses when stepping off the notch.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pos_q   <= '0;
      ring_q  <= '0;
      carry_q <= 1'b0;
    end else if (load_i) begin
      // NOTE: non-blocking updates mean the translation paths this cycle still see the old pos/ring.
      pos_q   <= mod_add({1'b0, pos_i}, '0, NV);
      ring_q  <= mod_add({1'b0, ring_i}, '0, NV);
      carry_q <= 1'b0;
    end else if (step_i) begin
      pos_q   <= mod_add({1'b0, pos_q}, (W+1)'(1), NV);
      carry_q <= (pos_q == NOTCH_IDX);
    end else begin
      carry_q <= 1'b0;
    end
  end

  // Output pipeline: results are zeroed whenever the matching request was idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fwd_valid_o <= 1'b0;
      fwd_o       <= '0;
      fwd_err_o   <= 1'b0;
      inv_valid_o <= 1'b0;
      inv_o       <= '0;
      inv_err_o   <= 1'b0;
    end else begin
      fwd_valid_o <= fwd_valid_i;
      fwd_o       <= fwd_valid_i ? fwd_res : '0;
      fwd_err_o   <= fwd_valid_i & fwd_bad;
      inv_valid_o <= inv_valid_i;
      inv_o       <= inv_valid_i ? inv_res : '0;
      inv_err_o   <= inv_valid_i & inv_bad;
    end
  end

  assign pos_o      = pos_q;
  assign at_notch_o = (pos_q == NOTCH_IDX);
  assign carry_o    = carry_q;

endmodule

// File: tb/tb_stepping_rotor.sv
// Self-checking bench for stepping_rotor with rotor I wiring: a letter-level
// model predicts every output each cycle; directed cases pin known letters.
module tb_stepping_rotor;

  localparam int N     = 26;
  localparam int W     = 5;
  localparam int NOTCH = 16;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b1;
  logic         load_i = 1'b0;
  logic [W-1:0] pos_i = '0;
  logic [W-1:0] ring_i = '0;
  logic         step_i = 1'b0;
  logic         fwd_valid_i = 1'b0;
  logic [N-1:0] fwd_i = '0;
  logic         inv_valid_i = 1'b0;
  logic [N-1:0] inv_i = '0;
  logic         fwd_valid_o;
  logic [N-1:0] fwd_o;
  logic         fwd_err_o;
  logic         inv_valid_o;
  logic [N-1:0] inv_o;
  logic         inv_err_o;
  logic [W-1:0] pos_o;
  logic         at_notch_o;
  logic         carry_o;

  stepping_rotor dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .load_i      (load_i),
    .pos_i       (pos_i),
    .ring_i      (ring_i),
    .step_i      (step_i),
    .fwd_valid_i (fwd_valid_i),
    .fwd_i       (fwd_i),
    .inv_valid_i (inv_valid_i),
    .inv_i       (inv_i),
    .fwd_valid_o (fwd_valid_o),
    .fwd_o       (fwd_o),
    .fwd_err_o   (fwd_err_o),
    .inv_valid_o (inv_valid_o),
    .inv_o       (inv_o),
    .inv_err_o   (inv_err_o),
    .pos_o       (pos_o),
    .at_notch_o  (at_notch_o),
    .carry_o     (carry_o)
  );

  always #5 CLK = ~CLK;

  int tests_run    = 0;
  int tests_failed = 0;
  int wire_f[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rotor I as letters, so the model does not depend on the package encoding.
  initial begin
    string s;
    s = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    for (int k = 0; k < 26; k++) wire_f[k] = int'(s[k]) - 65;
  end

  function automatic int letter_index(input logic [N-1:0] v);
    int found;
    found = -1;
    if ($countones(v) != 1) return -1;
    for (int k = 0; k < N; k++) if (v[k]) found = k;
    return found;
  endfunction

  function automatic logic [N-1:0] translate(input logic [N-1:0] v, input int pos,
                                             input int ring, input bit inverse);
    int i, off, c, j;
    i = letter_index(v);
    if (i < 0) return '0;
    off = (pos - ring + 26) % 26;
    c   = (i + off) % 26;
    j   = 0;
    if (!inverse) j = wire_f[c];
    else for (int k = 0; k < 26; k++) if (wire_f[k] == c) j = k;
    return N'(1) << ((j - off + 26) % 26);
  endfunction

  // Reference model: rotor state plus the outputs expected after each edge.
  int           m_pos = 0;
  int           m_ring = 0;
  logic         e_fv = 1'b0, e_fe = 1'b0, e_iv = 1'b0, e_ie = 1'b0, e_carry = 1'b0;
  logic [N-1:0] e_fo = '0, e_io = '0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_pos <= 0; m_ring <= 0; e_carry <= 1'b0;
      e_fv <= 1'b0; e_fo <= '0; e_fe <= 1'b0;
      e_iv <= 1'b0; e_io <= '0; e_ie <= 1'b0;
    end else begin
      e_fv <= fwd_valid_i;
      e_fo <= fwd_valid_i ? translate(fwd_i, m_pos, m_ring, 1'b0) : '0;
      e_fe <= fwd_valid_i && (letter_index(fwd_i) < 0);
      e_iv <= inv_valid_i;
      e_io <= inv_valid_i ? translate(inv_i, m_pos, m_ring, 1'b1) : '0;
      e_ie <= inv_valid_i && (letter_index(inv_i) < 0);
      if (load_i) begin
        m_pos   <= int'(pos_i) % 26;
        m_ring  <= int'(ring_i) % 26;
        e_carry <= 1'b0;
      end else if (step_i) begin
        m_pos   <= (m_pos + 1) % 26;
        e_carry <= (m_pos == NOTCH);
      end else begin
        e_carry <= 1'b0;
      end
    end
  end

  // Every-cycle comparison, sampled mid-period away from the rising edge.
  always @(negedge CLK) begin
    check("pos_o",       32'(pos_o),       32'(m_pos));
    check("at_notch_o",  32'(at_notch_o),  32'(m_pos == NOTCH));
    check("carry_o",     32'(carry_o),     32'(e_carry));
    check("fwd_valid_o", 32'(fwd_valid_o), 32'(e_fv));
    check("fwd_o",       32'(fwd_o),       32'(e_fo));
    check("fwd_err_o",   32'(fwd_err_o),   32'(e_fe));
    check("inv_valid_o", 32'(inv_valid_o), 32'(e_iv));
    check("inv_o",       32'(inv_o),       32'(e_io));
    check("inv_err_o",   32'(inv_err_o),   32'(e_ie));
  end

  // One clock of stimulus; returns 1 time unit after the rising edge.
  task automatic drive(input bit ld, input int p, input int r, input bit st,
                       input bit fv, input logic [N-1:0] fi,
                       input bit iv, input logic [N-1:0] ii);
    @(negedge CLK);
    load_i = ld; pos_i = W'(p); ring_i = W'(r); step_i = st;
    fwd_valid_i = fv; fwd_i = fi; inv_valid_i = iv; inv_i = ii;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [N-1:0] rand_letter();
    if ($urandom_range(9) == 0) return N'($urandom);
    return N'(1) << $urandom_range(25);
  endfunction

  initial begin
    #1 RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset pos_o",    32'(pos_o),       32'd0);
    check("reset at_notch", 32'(at_notch_o),  32'd0);
    check("reset fwd_valid",32'(fwd_valid_o), 32'd0);
    check("reset carry",    32'(carry_o),     32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Rotor I at AA: A -> E forward, E -> A inverse.
    drive(1, 0, 0, 0, 0, '0, 0, '0);
    drive(0, 0, 0, 0, 1, 26'h1, 1, 26'h10);
    check("AA fwd A", 32'(fwd_o), 32'h10);
    check("AA inv E", 32'(inv_o), 32'h1);
    check("AA valid", 32'({fwd_valid_o, inv_valid_o, fwd_err_o, inv_err_o}), 32'hC);

    drive(1, 1, 0, 0, 0, '0, 0, '0);
    drive(0, 0, 0, 0, 1, 26'h1, 0, '0);
    check("pos1 fwd A", 32'(fwd_o), 32'h200);

    drive(1, 0, 1, 0, 0, '0, 0, '0);
    drive(0, 0, 0, 0, 1, 26'h1, 0, '0);
    check("ring1 fwd A", 32'(fwd_o), 32'h400);

    // Turnover at Q and wrap from Z.
    drive(1, 16, 0, 0, 0, '0, 0, '0);
    check("at notch", 32'(at_notch_o), 32'd1);
    drive(0, 0, 0, 1, 0, '0, 0, '0);
    check("step pos", 32'(pos_o), 32'd17);
    check("step carry", 32'(carry_o), 32'd1);
    check("left notch", 32'(at_notch_o), 32'd0);
    drive(0, 0, 0, 0, 0, '0, 0, '0);
    check("carry one cycle", 32'(carry_o), 32'd0);
    drive(1, 25, 0, 0, 0, '0, 0, '0);
    drive(0, 0, 0, 1, 0, '0, 0, '0);
    check("wrap pos", 32'(pos_o), 32'd0);
    check("wrap carry", 32'(carry_o), 32'd0);

    // Load wins over step even from the notch position.
    drive(1, 16, 0, 0, 0, '0, 0, '0);
    drive(1, 5, 0, 1, 0, '0, 0, '0);
    check("load+step pos", 32'(pos_o), 32'd5);
    check("load+step carry", 32'(carry_o), 32'd0);

    // Translation during a step uses the old position.
    drive(1, 0, 0, 0, 0, '0, 0, '0);
    drive(0, 0, 0, 1, 1, 26'h1, 0, '0);
    check("step-cycle fwd A", 32'(fwd_o), 32'h10);
    check("step-cycle pos", 32'(pos_o), 32'd1);

    // Malformed forward input alongside a good inverse request.
    drive(1, 0, 0, 0, 0, '0, 0, '0);
    drive(0, 0, 0, 0, 1, 26'h3, 1, 26'h10);
    check("bad fwd out", 32'(fwd_o), 32'd0);
    check("bad fwd flags", 32'({fwd_valid_o, fwd_err_o}), 32'h3);
    check("good inv beside bad", 32'({inv_o, inv_err_o}), 32'h2);
    drive(0, 0, 0, 0, 1, '0, 0, '0);
    check("zero fwd err", 32'({fwd_valid_o, fwd_err_o, fwd_o}), 32'h3 << 26);

    // Asynchronous reset with requests in flight.
    drive(1, 12, 3, 0, 0, '0, 0, '0);
    drive(0, 0, 0, 0, 1, 26'h1, 1, 26'h1);
    check("pre-reset valid", 32'({fwd_valid_o, inv_valid_o}), 32'h3);
    #1 RST_N = 1'b0;
    #1;
    check("async rst outs", 32'({fwd_valid_o, inv_valid_o, fwd_err_o, inv_err_o, carry_o}), 32'd0);
    check("async rst fwd_o", 32'(fwd_o), 32'd0);
    check("async rst inv_o", 32'(inv_o), 32'd0);
    check("async rst pos", 32'(pos_o), 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    fwd_valid_i = 1'b0; inv_valid_i = 1'b0; RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check("post-rst no valid", 32'({fwd_valid_o, inv_valid_o}), 32'd0);

    // Every position/ring pair: A forward and a random inverse letter.
    for (int p = 0; p < 26; p++) begin
      for (int r = 0; r < 26; r++) begin
        drive(1, p, r, 0, 0, '0, 0, '0);
        drive(0, 0, 0, 0, 1, 26'h1, 1, N'(1) << $urandom_range(25));
      end
    end

    // Random traffic, including out-of-range loads and malformed letters.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(7) == 0, int'($urandom_range(31)), int'($urandom_range(31)),
            $urandom_range(2) == 0,
            $urandom_range(1) == 1, rand_letter(),
            $urandom_range(1) == 1, rand_letter());
    end
    drive(0, 0, 0, 0, 0, '0, 0, '0);
    @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
